// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter in front of a single-port registered-read RAM
// Grants are combinational; lock state, priority and read-valid flags are registered.
module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  output logic [ADDR_WIDTH-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_t;

  lock_t lock_state;
  logic  prio;
  logic  cand0;
  logic  cand1;

  // A port locked out by the other's lock is not a candidate; reset masks both at once.
  assign cand0 = req0 && (lock_state != LOCKED1) && !reset;
  assign cand1 = req1 && (lock_state != LOCKED0) && !reset;
  assign gnt0  = cand0 && (!cand1 || !prio);
  assign gnt1  = cand1 && (!cand0 || prio);

  assign rdata0 = ram_dout;
  assign rdata1 = ram_dout;

  always_comb begin
    ram_read_address  = '0;
    ram_write_address = '0;
    ram_din           = '0;
    ram_write         = 1'b0;
    if (gnt0) begin
      ram_read_address  = addr0;
      ram_write_address = addr0;
      ram_din           = wdata0;
      ram_write         = we0;
    end else if (gnt1) begin
      ram_read_address  = addr1;
      ram_write_address = addr1;
      ram_din           = wdata1;
      ram_write         = we1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio       <= 1'b0;
      lock_state <= UNLOCKED;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0)      prio <= 1'b1;
      else if (gnt1) prio <= 1'b0;
      case (lock_state)
        UNLOCKED: begin
          if (gnt0 && lock0)      lock_state <= LOCKED0;
          else if (gnt1 && lock1) lock_state <= LOCKED1;
        end
        // Owner releases by an unlocked access or by dropping its request for a cycle.
        LOCKED0: if ((gnt0 && !lock0) || !req0) lock_state <= UNLOCKED;
        LOCKED1: if ((gnt1 && !lock1) || !req1) lock_state <= UNLOCKED;
        default: lock_state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, RAM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, RAM address width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request, held high until granted.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read, valid while reqN high.
REQ-007 lock0, lock1  input  1 each  requests the RAM be held for the next access by the same port.
REQ-008 addr0, addr1  input  ADDR_WIDTH each  access address.
REQ-009 wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-010 gnt0, gnt1  output  1 each  access accepted this cycle (combinational).
REQ-011 rvalid0, rvalid1  output  1 each  read data valid this cycle (registered).
REQ-012 rdata0, rdata1  output  DATA_WIDTH each  read data, both driven from ram_dout.
REQ-013 ram_read_address, ram_write_address  output  ADDR_WIDTH each  to RAM.
REQ-014 ram_write  output  1  RAM write enable.
REQ-015 ram_din  output  DATA_WIDTH  RAM write data.
REQ-016 ram_dout  input  DATA_WIDTH  RAM registered read data, valid one cycle after the read address is sampled.

Function
REQ-017 At most one of gnt0/gnt1 SHALL be high in any cycle; a grant requires the matching reqN high.
REQ-018 Arbitration: round-robin via 1-bit priority register prio; prio=0 favours port 0, prio=1 favours port 1; a lone requester is always granted (unless locked out, REQ-022).
REQ-019 On each grant, prio SHALL update at the clock edge to favour the non-granted port; no grant -> prio unchanged.
REQ-020 Granted port N SHALL drive ram_read_address=addrN, ram_write_address=addrN, ram_din=wdataN, ram_write=weN in the same cycle; with no grant, ram_write=0, addresses=0, ram_din=0.
REQ-021 Read latency: grant with weN=0 in cycle T -> rvalidN=1 for exactly cycle T+1, rdataN=ram_dout; writes never raise rvalid.
REQ-022 Lock FSM states UNLOCKED, LOCKED0, LOCKED1: grant to port N with lockN=1 -> LOCKEDN; in LOCKEDN only port N may be granted; LOCKEDN -> UNLOCKED when port N is granted with lockN=0 or reqN is low for a cycle.
REQ-023 Back-to-back grants every cycle SHALL be supported; rvalid for a read in T and a grant in T+1 coexist.
REQ-024 A request whose addr/we/wdata change before grant uses the values present in the grant cycle.
REQ-025 rdata0/rdata1 outside rvalid cycles are don't-care.

Reset
REQ-026 While reset is high: gnt0=gnt1=0, ram_write=0, rvalid0=rvalid1=0, prio=0, lock state UNLOCKED, regardless of clk.
REQ-027 Reset asserted the cycle after a read grant SHALL suppress that rvalid; the read is lost and must be re-requested.
REQ-028 First arbitration after reset deasserts favours port 0.

Verification
REQ-029 After reset, req0=req1=1 both reads, addr0=3, addr1=5 -> gnt0 cycle 1, rvalid0 cycle 2 with mem[3]; gnt1 cycle 2, rvalid1 cycle 3 with mem[5].
REQ-030 Port 1 writes 0xDEADBEEF to addr 7, then port 0 reads addr 7 -> ram_write=1 only in write grant cycle; rvalid0 one cycle after read grant with rdata0=0xDEADBEEF.
REQ-031 req0 alone held for 4 cycles -> gnt0 every cycle, prio ends at 1, gnt1 never high.
REQ-032 Port 0 granted with lock0=1, req1 held high, port 0 issues 3 more accesses (last with lock0=0) -> gnt1 low until the cycle after port 0's unlocked grant.
REQ-033 Read granted, reset pulsed asynchronously mid-next-cycle -> rvalid drops immediately, all outputs at REQ-026 values, next contention grants port 0.
REQ-034 Random req/we/lock on both ports for 10k cycles against a scoreboard model -> never both gnts, every read returns last value written to its address, no rvalid without a prior read grant.
